// File: rtl/alu_issue_stage.sv
// Issue stage for an external combinational ALU: registers one operation, samples the
// ALU outputs one cycle later and holds the result until it is handed off downstream.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no operation in flight, ready for a request
//   EXEC  | operands registered on alu_*, ALU outputs sampled at end of cycle
//   DONE  | result held on out_*; handoff may accept the next request
module alu_issue_stage #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [3:0]   in_control,
    input  logic         in_use_acc,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_control,
    input  logic [N-1:0] alu_result,
    input  logic         alu_v,
    input  logic         alu_c,
    input  logic         alu_n,
    input  logic         alu_z,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [3:0]   out_flags,
    output logic         out_illegal,
    output logic [7:0]   op_count
);

    localparam logic [3:0] OP_MAX_LEGAL = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] acc;
    logic         accept;
    logic         handoff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = in_valid ? EXEC : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign handoff = out_valid && out_ready;

    // acc already holds the result being handed off, so a back-to-back accept sees it
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            acc         <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_flags   <= '0;
            out_illegal <= 1'b0;
            op_count    <= '0;
        end else begin
            if (accept) begin
                alu_a       <= in_use_acc ? acc : in_a;
                alu_b       <= in_b;
                alu_control <= in_control;
            end
            if (state == EXEC) begin
                out_result  <= alu_result;
                acc         <= alu_result;
                out_flags   <= {alu_v, alu_c, alu_n, alu_z};
                out_illegal <= (alu_control > OP_MAX_LEGAL);
                out_valid   <= 1'b1;
            end else if (handoff) begin
                out_valid   <= 1'b0;
            end
            if (handoff) begin
                op_count <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU on the alu_* port, transaction-level
// reference model, directed scenarios followed by randomized traffic.
module tb_alu_issue_stage;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [3:0]   in_control;
    logic         in_use_acc;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_control;
    logic [N-1:0] alu_result;
    logic         alu_v;
    logic         alu_c;
    logic         alu_n;
    logic         alu_z;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result;
    logic [3:0]   out_flags;
    logic         out_illegal;
    logic [7:0]   op_count;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic         m_busy;
    logic         m_out_valid;
    logic [3:0]   m_res;
    logic [3:0]   m_flags;
    logic         m_ill;
    logic [3:0]   m_acc;
    logic [3:0]   m_a;
    logic [3:0]   m_b;
    logic [3:0]   m_ctl;
    logic [7:0]   m_count;

    alu_issue_stage #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_control  (in_control),
        .in_use_acc  (in_use_acc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_v       (alu_v),
        .alu_c       (alu_c),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .out_illegal (out_illegal),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // returns {v, c, n, z, result}
    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] ctl);
        logic [4:0] s;
        logic [3:0] r;
        logic       v;
        logic       c;
        v = 1'b0;
        c = 1'b0;
        r = a;
        case (ctl)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0];
                c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a >> b;
            4'd6:    r = a << b;
            default: r = a;
        endcase
        return {v, c, r[3], (r == 4'd0), r};
    endfunction

    always_comb {alu_v, alu_c, alu_n, alu_z, alu_result} = alu_ref(alu_a, alu_b, alu_control);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy      = 1'b0;
        m_out_valid = 1'b0;
        m_res       = '0;
        m_flags     = '0;
        m_ill       = 1'b0;
        m_acc       = '0;
        m_a         = '0;
        m_b         = '0;
        m_ctl       = '0;
        m_count     = '0;
    endtask

    // One clock: drive just after the edge, compare at the falling edge, advance the model.
    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ctl, input logic ua, input logic ordy,
                        input logic r);
        logic       exp_rdy;
        logic       acc_ok;
        logic       hand;
        logic [7:0] f;
        rst        = r;
        in_valid   = v;
        in_a       = a;
        in_b       = b;
        in_control = ctl;
        in_use_acc = ua;
        out_ready  = ordy;
        @(negedge clk);
        exp_rdy = !m_busy && (!m_out_valid || ordy);
        check("in_ready",    {31'd0, in_ready},    {31'd0, exp_rdy});
        check("out_valid",   {31'd0, out_valid},   {31'd0, m_out_valid});
        check("out_result",  {28'd0, out_result},  {28'd0, m_res});
        check("out_flags",   {28'd0, out_flags},   {28'd0, m_flags});
        check("out_illegal", {31'd0, out_illegal}, {31'd0, m_ill});
        check("op_count",    {24'd0, op_count},    {24'd0, m_count});
        check("alu_a",       {28'd0, alu_a},       {28'd0, m_a});
        check("alu_b",       {28'd0, alu_b},       {28'd0, m_b});
        check("alu_control", {28'd0, alu_control}, {28'd0, m_ctl});
        if (r) begin
            model_reset();
        end else begin
            acc_ok = v && exp_rdy;
            hand   = m_out_valid && ordy;
            if (hand) begin
                m_count     = m_count + 8'd1;
                m_out_valid = 1'b0;
            end
            if (m_busy) begin
                f           = alu_ref(m_a, m_b, m_ctl);
                m_res       = f[3:0];
                m_flags     = f[7:4];
                m_ill       = (m_ctl > 4'd6);
                m_acc       = f[3:0];
                m_out_valid = 1'b1;
                m_busy      = 1'b0;
            end
            if (acc_ok) begin
                m_a    = ua ? m_acc : a;
                m_b    = b;
                m_ctl  = ctl;
                m_busy = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic ordy);
        step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, ordy, 1'b0);
    endtask

    task automatic reset_cycle();
        step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0] held_res;
        logic [7:0] held_cnt;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_control = '0;
        in_use_acc = 1'b0;
        out_ready  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_cycle();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_op_count", {24'd0, op_count}, 32'd0);

        // add 3+5
        step(1'b1, 4'd3, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0);
        check("add_not_valid_yet", {31'd0, out_valid}, 32'd0);
        idle_cycle(1'b0);
        check("add_valid",  {31'd0, out_valid},  32'd1);
        check("add_result", {28'd0, out_result}, 32'd8);
        check("add_flags",  {28'd0, out_flags},  32'b1010);
        idle_cycle(1'b1);
        check("add_count",  {24'd0, op_count},   32'd1);
        check("add_drop",   {31'd0, out_valid},  32'd0);

        // subtract equal operands
        step(1'b1, 4'd5, 4'd5, 4'd1, 1'b0, 1'b0, 1'b0);
        idle_cycle(1'b0);
        check("sub_result", {28'd0, out_result}, 32'd0);
        check("sub_flags",  {28'd0, out_flags},  32'b0101);
        idle_cycle(1'b1);

        // accumulate chain issued back-to-back during handoff
        reset_cycle();
        step(1'b1, 4'd2, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
        idle_cycle(1'b0);
        check("chain_first", {28'd0, out_result}, 32'd5);
        step(1'b1, 4'd9, 4'd4, 4'd0, 1'b1, 1'b1, 1'b0);
        check("chain_alu_a", {28'd0, alu_a}, 32'd5);
        idle_cycle(1'b0);
        check("chain_second", {28'd0, out_result}, 32'd9);
        idle_cycle(1'b1);
        check("chain_count", {24'd0, op_count}, 32'd2);

        // backpressure while a new request waits
        step(1'b1, 4'd7, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0);
        idle_cycle(1'b0);
        held_res = out_result;
        held_cnt = op_count;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'd15, 4'd15, 4'd3, 1'b0, 1'b0, 1'b0);
            check("bp_in_ready", {31'd0, in_ready},   32'd0);
            check("bp_result",   {28'd0, out_result}, {28'd0, held_res});
            check("bp_count",    {24'd0, op_count},   {24'd0, held_cnt});
        end
        check("bp_alu_a", {28'd0, alu_a}, 32'd7);
        idle_cycle(1'b1);

        // illegal opcode passes A through and is flagged
        step(1'b1, 4'd6, 4'd2, 4'd12, 1'b0, 1'b0, 1'b0);
        idle_cycle(1'b0);
        check("ill_flag",   {31'd0, out_illegal}, 32'd1);
        check("ill_result", {28'd0, out_result},  32'd6);
        step(1'b1, 4'd1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0);
        idle_cycle(1'b0);
        check("legal_after_ill", {31'd0, out_illegal}, 32'd0);
        idle_cycle(1'b1);

        // reset during EXEC, then during DONE with a handshake pending
        step(1'b1, 4'd4, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b1);
        check("rst_exec_valid", {31'd0, out_valid}, 32'd0);
        check("rst_exec_ready", {31'd0, in_ready},  32'd1);
        check("rst_exec_count", {24'd0, op_count}, 32'd0);
        check("rst_exec_alu_a", {28'd0, alu_a},    32'd0);
        step(1'b1, 4'd4, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0);
        idle_cycle(1'b0);
        step(1'b1, 4'd3, 4'd3, 4'd1, 1'b0, 1'b1, 1'b1);
        check("rst_done_valid",  {31'd0, out_valid},  32'd0);
        check("rst_done_result", {28'd0, out_result}, 32'd0);
        check("rst_done_flags",  {28'd0, out_flags},  32'd0);
        check("rst_done_count",  {24'd0, op_count},   32'd0);

        // sustained back-to-back traffic wraps op_count
        for (int i = 0; i < 560; i++) begin
            step(1'b1, 4'($urandom), 4'($urandom), 4'($urandom_range(0, 6)),
                 1'($urandom), 1'b1, 1'b0);
        end
        check("wrap_count", {24'd0, op_count}, {24'd0, m_count});

        // randomized traffic with stalls and occasional resets
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 4'($urandom),
                 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
